// File: rtl/riscv_pkg.sv
// Shared RV32I core definitions: register-file geometry and the basic scalar types.
// Imported by the register file, its write decoder and the port interface.
package riscv_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]       xlen_t;

    localparam reg_addr_t REG_ZERO = 5'd0;

endpackage

// File: rtl/reg_file_wr_demux_if.sv
// Read/write port bundle of the integer register file.
// The master (decode/writeback) drives addresses and write data; the slave (regfile) returns read data.
interface reg_file_wr_demux_if
    import riscv_pkg::*;
#(
    parameter int DATA_WIDTH = XLEN,
    parameter int ADDR_WIDTH = REG_ADDR_W
);

    logic [ADDR_WIDTH-1:0]    a1;
    logic [ADDR_WIDTH-1:0]    a2;
    logic [ADDR_WIDTH-1:0]    a3;
    logic                     we3;
    logic [DATA_WIDTH-1:0]    wd3;
    logic [DATA_WIDTH-1:0]    rd1;
    logic [DATA_WIDTH-1:0]    rd2;
    logic [2**ADDR_WIDTH-1:0] wr_onehot;

    modport master (
        output a1, a2, a3, we3, wd3,
        input  rd1, rd2, wr_onehot
    );

    modport slave (
        input  a1, a2, a3, we3, wd3,
        output rd1, rd2, wr_onehot
    );

endinterface

// File: rtl/wr_decoder.sv
// ADDR_WIDTH-to-2**ADDR_WIDTH one-hot write decoder with enable.
// Bit 0 is forced low so the hardwired zero register can never be written.
module wr_decoder
    import riscv_pkg::*;
#(
    parameter int ADDR_WIDTH = REG_ADDR_W
) (
    input  logic                     en,
    input  logic [ADDR_WIDTH-1:0]    addr,
    output logic [2**ADDR_WIDTH-1:0] onehot
);

    // NOTE: default every combinational output first so no path leaves it unassigned (no latch).
    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[addr] = 1'b1;
        end
        onehot[0] = 1'b0;
    end

endmodule

// File: rtl/reg_file_wr_demux.sv
// RV32I integer register file: 2**ADDR_WIDTH x DATA_WIDTH, one synchronous write port, two combinational read ports.
// Define REGFILE_BYPASS_EN to forward same-cycle write data onto the read ports.
module reg_file_wr_demux
    import riscv_pkg::*;
#(
    parameter int DATA_WIDTH = XLEN,
    parameter int ADDR_WIDTH = REG_ADDR_W
) (
    input  logic               clk,
    input  logic               reset,
    reg_file_wr_demux_if.slave bus
);

    localparam int                    NUM_REGS  = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = ADDR_WIDTH'(REG_ZERO);

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
    logic [NUM_REGS-1:0]   wr_en;
    logic                  dec_en;
    logic [DATA_WIDTH-1:0] rd1_stored;
    logic [DATA_WIDTH-1:0] rd2_stored;

    // Writes are blocked while reset is high, so the decode enable is gated here.
    assign dec_en = bus.we3 & ~reset;

    wr_decoder #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_wr_decoder (
        .en     (dec_en),
        .addr   (bus.a3),
        .onehot (wr_en)
    );

    assign bus.wr_onehot = wr_en;

    always_comb begin
        regs_d = regs_q;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (wr_en[i]) begin
                regs_d[i] = bus.wd3;
            end
        end
        regs_d[0] = '0;
    end

    // NOTE: this storage carries an async reset because the core relies on a cleared register file
    // after reset; sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Address 0 and reset are gated on the read side as well, so x0 reads 0 even before the first reset.
    always_comb begin
        rd1_stored = '0;
        rd2_stored = '0;
        if (!reset && bus.a1 != ADDR_ZERO) begin
            rd1_stored = regs_q[bus.a1];
        end
        if (!reset && bus.a2 != ADDR_ZERO) begin
            rd2_stored = regs_q[bus.a2];
        end
    end

`ifdef REGFILE_BYPASS_EN
    // wr_en already folds in we3, a3 != 0 and ~reset, so one bit selects the forward.
    always_comb begin
        bus.rd1 = wr_en[bus.a1] ? bus.wd3 : rd1_stored;
        bus.rd2 = wr_en[bus.a2] ? bus.wd3 : rd2_stored;
    end
`else
    always_comb begin
        bus.rd1 = rd1_stored;
        bus.rd2 = rd2_stored;
    end
`endif

endmodule

// File: tb/tb_reg_file_wr_demux.sv
// Directed self-checking bench for reg_file_wr_demux.
// Inputs change on the falling edge; outputs are sampled #1 after an edge or mid-cycle.
module tb_reg_file_wr_demux;
    import riscv_pkg::*;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    reg_file_wr_demux_if #(.DATA_WIDTH(XLEN), .ADDR_WIDTH(REG_ADDR_W)) bus ();

    reg_file_wr_demux #(
        .DATA_WIDTH (XLEN),
        .ADDR_WIDTH (REG_ADDR_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic write_reg(input reg_addr_t addr, input xlen_t data);
        @(negedge clk);
        bus.we3 = 1'b1;
        bus.a3  = addr;
        bus.wd3 = data;
        @(posedge clk);
        #1;
        bus.we3 = 1'b0;
    endtask

    initial begin
        xlen_t     exp1;
        xlen_t     exp2;
        xlen_t     same_cycle_exp;
        reg_addr_t ra;

        checks  = 0;
        errors  = 0;
        reset   = 1'b1;
        bus.a1  = 5'd5;
        bus.a2  = 5'd0;
        bus.a3  = 5'd5;
        bus.we3 = 1'b1;
        bus.wd3 = 32'hCAFE_F00D;

        // Reset state: writes blocked, reads and decode all zero.
        repeat (2) @(posedge clk);
        #1;
        check("reset_rd1", bus.rd1, 32'h0);
        check("reset_rd2", bus.rd2, 32'h0);
        check("reset_onehot", bus.wr_onehot, 32'h0);

        @(negedge clk);
        bus.we3 = 1'b0;
        reset   = 1'b0;

        // Async reset between edges clears x5 immediately.
        write_reg(5'd5, 32'hDEAD_BEEF);
        bus.a1 = 5'd5;
        #1;
        check("x5_written", bus.rd1, 32'hDEAD_BEEF);
        @(negedge clk);
        bus.we3 = 1'b1;
        bus.a3  = 5'd7;
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_rd1", bus.rd1, 32'h0);
        check("async_reset_onehot", bus.wr_onehot, 32'h0);
        bus.we3 = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        // Write x1..x31 with i * 0x01010101; check decode during each write.
        for (int i = 1; i < 32; i++) begin
            @(negedge clk);
            bus.we3 = 1'b1;
            bus.a3  = 5'(i);
            bus.wd3 = 32'(i) * 32'h0101_0101;
            #1;
            if (i == 7) check("onehot_x7", bus.wr_onehot, 32'h0000_0080);
            else        check("onehot_write", bus.wr_onehot, 32'h1 << i);
            @(posedge clk);
            #1;
            bus.we3 = 1'b0;
        end

        // Sweep both read ports in opposite directions.
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            bus.a1 = 5'(i);
            bus.a2 = 5'(31 - i);
            exp1   = 32'(i) * 32'h0101_0101;
            exp2   = 32'(31 - i) * 32'h0101_0101;
            #1;
            check("sweep_rd1", bus.rd1, exp1);
            check("sweep_rd2", bus.rd2, exp2);
        end

        // x0 protection.
        @(negedge clk);
        bus.we3 = 1'b1;
        bus.a3  = 5'd0;
        bus.wd3 = 32'hFFFF_FFFF;
        bus.a1  = 5'd0;
        #1;
        check("x0_onehot", bus.wr_onehot, 32'h0);
        @(posedge clk);
        #1;
        bus.we3 = 1'b0;
        check("x0_rd1", bus.rd1, 32'h0);

        // Write disabled: x3 must hold across three edges.
        write_reg(5'd3, 32'h1234_5678);
        @(negedge clk);
        bus.we3 = 1'b0;
        bus.a3  = 5'd3;
        bus.wd3 = 32'hAAAA_AAAA;
        bus.a2  = 5'd3;
        #1;
        check("we0_onehot", bus.wr_onehot, 32'h0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            check("we0_hold_x3", bus.rd2, 32'h1234_5678);
        end

        // Same-cycle read and write of x9.
        write_reg(5'd9, 32'h0000_0011);
`ifdef REGFILE_BYPASS_EN
        same_cycle_exp = 32'h0000_0022;
`else
        same_cycle_exp = 32'h0000_0011;
`endif
        @(negedge clk);
        ra      = 5'd9;
        bus.a1  = ra;
        bus.a2  = ra;
        bus.a3  = ra;
        bus.we3 = 1'b1;
        bus.wd3 = 32'h0000_0022;
        #1;
        check("same_cycle_rd1_pre", bus.rd1, same_cycle_exp);
        check("same_cycle_rd2_pre", bus.rd2, same_cycle_exp);
        @(posedge clk);
        #1;
        bus.we3 = 1'b0;
        check("same_cycle_rd1_post", bus.rd1, 32'h0000_0022);
        check("same_cycle_rd2_post", bus.rd2, 32'h0000_0022);

        // Dual-port read of two different registers.
        write_reg(5'd4, 32'h0000_0044);
        write_reg(5'd31, 32'hF1F1_F1F1);
        @(negedge clk);
        bus.a1 = 5'd4;
        bus.a2 = 5'd31;
        #1;
        check("dual_rd1", bus.rd1, 32'h0000_0044);
        check("dual_rd2", bus.rd2, 32'hF1F1_F1F1);

        // Untouched neighbour kept its sweep value.
        bus.a1 = 5'd30;
        #1;
        check("x30_untouched", bus.rd1, 32'h1E1E_1E1E);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_file_wr_demux.md
Name: reg_file_wr_demux

Overview:
- Integer register file for the pipelined RV32I core: 32 x 32-bit registers, one synchronous write port, two combinational read ports.
- Write side decodes the destination address into a one-hot enable, the inverse of the read-side select muxes.
- Instantiated in the decode stage. Writeback drives the write port; decode reads rs1/rs2.

Parameters:
- DATA_WIDTH, 32, register width in bits
- ADDR_WIDTH, 5, register address width; number of registers = 2**ADDR_WIDTH

Ports:
- clk  input  1  core clock, rising-edge active
- reset  input  1  asynchronous active-high reset; all registers cleared
- a1  input  ADDR_WIDTH  read port 1 address (rs1)
- a2  input  ADDR_WIDTH  read port 2 address (rs2)
- a3  input  ADDR_WIDTH  write address (rd)
- we3  input  1  write enable
- wd3  input  DATA_WIDTH  write data
- rd1  output  DATA_WIDTH  read port 1 data
- rd2  output  DATA_WIDTH  read port 2 data
- wr_onehot  output  2**ADDR_WIDTH  decoded write enable vector, debug/observability

Behaviour:
- Reset:
  - Asserting reset clears all registers to 0 asynchronously, independent of clk.
  - While reset is high, rd1 = rd2 = 0 for any address and wr_onehot = 0.
  - Writes are blocked while reset is high.
- Write:
  - On a rising edge of clk with reset low and we3 = 1, register[a3] <= wd3.
  - Write latency is 1 cycle: the new value is visible on read ports after the edge.
- Write decode:
  - wr_onehot[i] = we3 & (a3 == i) & ~reset, for i >= 1.
  - wr_onehot[0] is always 0.
  - At most one bit is set.
- x0:
  - Register 0 is hardwired to 0. Writes with a3 = 0 are dropped silently.
  - Reading a1 = 0 or a2 = 0 returns 0 always.
- Read:
  - Purely combinational: rd1 = register[a1], rd2 = register[a2].
  - Zero-cycle latency, no clock dependence.
- Simultaneous events:
  - Both read ports may address the same register and return identical data.
  - Read of the register being written in the same cycle returns the OLD value (pre-edge) unless REGFILE_BYPASS_EN is defined.
- we3 = 0: no register changes. wr_onehot = 0.
- Reset deasserted mid-cycle: the next rising edge performs a normal write if we3 = 1.
- Widths: no arithmetic. Every address value is valid because the register count is exactly 2**ADDR_WIDTH, so there is no out-of-range case.

Optional Feature:
- Macro: REGFILE_BYPASS_EN
- Defined:
  - Write-through forwarding. If we3 = 1, a3 != 0, reset = 0 and a1 == a3, then rd1 = wd3 combinationally in the same cycle. Same rule for a2/rd2.
  - Removes the writeback-to-decode hazard so the hazard unit needs no extra stall.
- Undefined:
  - Reads return stored contents only. Same-cycle read of a register being written returns the old value.

Decomposition:
- Shared package riscv_pkg holds:
  - REG_ADDR_W = 5, XLEN = 32, REG_ZERO = 5'd0
  - typedef reg_addr_t (logic [4:0])
  - typedef xlen_t (logic [31:0])
- One sub-module: wr_decoder.
  - Parameterised ADDR_WIDTH-to-2**ADDR_WIDTH one-hot decoder with enable input.
  - Forces bit 0 low.
  - Drives both wr_onehot and the per-register write enables.
- Storage and read muxing stay in the top module.

Test Plan:
- Reset: write 0xDEADBEEF to x5, then assert reset asynchronously between edges → rd1 (a1 = 5) becomes 0 immediately, before the next edge. wr_onehot = 0 while reset is high.
- Write/read all: for i = 1..31 write wd3 = i * 0x01010101 with we3 = 1. Then sweep a1/a2 → rd1/rd2 equal each written value. During the x7 write, wr_onehot = 32'h0000_0080.
- x0 protection: we3 = 1, a3 = 0, wd3 = 0xFFFFFFFF, clock edge → rd1 (a1 = 0) = 0 and wr_onehot = 0.
- Write disabled: x3 holds 0x12345678. Drive we3 = 0, a3 = 3, wd3 = 0xAAAAAAAA for 3 cycles → rd2 (a2 = 3) stays 0x12345678.
- Same-cycle read/write: x9 = 0x11, then a1 = a2 = 9, a3 = 9, we3 = 1, wd3 = 0x22. Before the edge, rd1 = rd2 = 0x11 without the macro and 0x22 with REGFILE_BYPASS_EN. After the edge, both read 0x22.
- Dual port: a1 = 4 (0x44), a2 = 31 (0xF1F1F1F1) in the same cycle → rd1 = 0x44, rd2 = 0xF1F1F1F1.
